fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: holds the program counter, drives the instruction ROM
// address and sequences IDLE -> RUN -> HALTED under start/halt/jump/branch control.
module fetch_unit #(
  parameter int unsigned pc_width    = 10,
  parameter int unsigned instr_width = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [pc_width-1:0]    start_addr,
  input  logic                   halt,
  input  logic                   jump,
  input  logic [pc_width-1:0]    jump_target,
  input  logic                   branch_taken,
  input  logic [7:0]             branch_offset,
  input  logic [instr_width-1:0] instr_rdata,
  output logic [pc_width-1:0]    instr_addr,
  output logic [instr_width-1:0] instruction,
  output logic                   instr_valid,
  output logic                   done,
  output logic [15:0]            cycle_count
);

  // HALT encoding (opcode 111, subop 11): the decoder issues no writes for it.
  localparam logic [instr_width-1:0] HaltInstr = instr_width'(9'h1C3);

  // Branch arithmetic width: wide enough for both the PC and the 8-bit offset.
  localparam int unsigned ExtWidth = (pc_width > 8) ? pc_width : 8;

  typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

  state_e              state_q, state_d;
  logic [pc_width-1:0] pc_q, pc_d;
  logic [15:0]         cnt_q, cnt_d;

  logic [ExtWidth-1:0] offset_ext;
  logic [ExtWidth-1:0] branch_sum;
  logic [pc_width-1:0] branch_pc;
  logic                launch;

  // Sign-extend the offset and add modulo 2^pc_width.
  assign offset_ext = ExtWidth'(signed'(branch_offset));
  assign branch_sum = ExtWidth'(pc_q) + offset_ext;
  assign branch_pc  = branch_sum[pc_width-1:0];

  // A start is honoured only from IDLE or HALTED.
  assign launch = start && (state_q != StRun);

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StRun;
      StRun:    if (halt)  state_d = StHalted;
      StHalted: if (start) state_d = StRun;
      default:  state_d = StIdle;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    instr_valid = 1'b0;
    done        = 1'b0;
    instruction = HaltInstr;
    unique case (state_q)
      StRun: begin
        instr_valid = 1'b1;
        instruction = instr_rdata;
      end
      StHalted: done = 1'b1;
      default: ;
    endcase
  end

  // Next PC: start load, else in RUN priority halt > jump > branch > increment.
  always_comb begin
    pc_d = pc_q;
    if (launch) begin
      pc_d = start_addr;
    end else if (state_q == StRun) begin
      if (halt) begin
        pc_d = pc_q;
      end else if (jump) begin
        pc_d = jump_target;
      end else if (branch_taken) begin
        pc_d = branch_pc;
      end else begin
        pc_d = pc_q + 1'b1;
      end
    end
  end

  // Next cycle count: cleared on start, saturating increment on every RUN cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (launch) begin
      cnt_d = '0;
    end else if (state_q == StRun && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // PC and cycle counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  assign instr_addr  = pc_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational ROM stand-in.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  start_addr;
  logic        halt;
  logic        jump;
  logic [9:0]  jump_target;
  logic        branch_taken;
  logic [7:0]  branch_offset;
  logic [8:0]  instr_rdata;
  logic [9:0]  instr_addr;
  logic [8:0]  instruction;
  logic        instr_valid;
  logic        done;
  logic [15:0] cycle_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // ROM contents: address low bits xor a constant.
  assign instr_rdata = instr_addr[8:0] ^ 9'h0A5;

  fetch_unit #(.pc_width(10), .instr_width(9)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .start_addr   (start_addr),
    .halt         (halt),
    .jump         (jump),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .instr_rdata  (instr_rdata),
    .instr_addr   (instr_addr),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .done         (done),
    .cycle_count  (cycle_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_run(input string tag, input logic [9:0] pc, input logic [15:0] cnt);
    check({tag, ".addr"}, 32'(instr_addr), 32'(pc));
    check({tag, ".valid"}, 32'(instr_valid), 32'd1);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".instr"}, 32'(instruction), 32'(pc[8:0] ^ 9'h0A5));
    check({tag, ".cnt"}, 32'(cycle_count), 32'(cnt));
  endtask

  task automatic check_stopped(input string tag, input logic [9:0] pc, input logic [15:0] cnt,
                               input logic exp_done);
    check({tag, ".addr"}, 32'(instr_addr), 32'(pc));
    check({tag, ".valid"}, 32'(instr_valid), 32'd0);
    check({tag, ".done"}, 32'(done), 32'(exp_done));
    check({tag, ".instr"}, 32'(instruction), 32'h1C3);
    check({tag, ".cnt"}, 32'(cycle_count), 32'(cnt));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_addr = '0; halt = 1'b0; jump = 1'b0;
    jump_target = '0; branch_taken = 1'b0; branch_offset = '0;
    step();
    step();
    check_stopped("reset", 10'h000, 16'd0, 1'b0);

    // Sequential run from 0x010.
    reset = 1'b0; start = 1'b1; start_addr = 10'h010;
    step();
    start = 1'b0;
    check_run("seq0", 10'h010, 16'd0);
    step(); check_run("seq1", 10'h011, 16'd1);
    step(); check_run("seq2", 10'h012, 16'd2);
    step(); check_run("seq3", 10'h013, 16'd3);
    step(); check_run("seq4", 10'h014, 16'd4);

    // Jump to 0x005, then branch back by 2.
    jump = 1'b1; jump_target = 10'h005;
    step(); check_run("jmp5", 10'h005, 16'd5);
    jump = 1'b0; branch_taken = 1'b1; branch_offset = 8'hFE;
    step(); check_run("brneg", 10'h003, 16'd6);
    // Jump to top of range, then plain increment wraps.
    branch_taken = 1'b0; jump = 1'b1; jump_target = 10'h3FF;
    step(); check_run("jmp3ff", 10'h3FF, 16'd7);
    jump = 1'b0;
    step(); check_run("wrap", 10'h000, 16'd8);
    // Jump beats branch; then a positive branch.
    jump = 1'b1; jump_target = 10'h200; branch_taken = 1'b1; branch_offset = 8'h7F;
    step(); check_run("jmp_over_br", 10'h200, 16'd9);
    jump = 1'b0;
    step(); check_run("brpos", 10'h27F, 16'd10);
    branch_taken = 1'b0; jump = 1'b1; jump_target = 10'h020;
    step(); check_run("jmp20", 10'h020, 16'd11);

    // All controls at once: halt wins.
    halt = 1'b1; jump = 1'b1; jump_target = 10'h155; branch_taken = 1'b1;
    step(); check_stopped("halted", 10'h020, 16'd12, 1'b1);
    step(); check_stopped("hold", 10'h020, 16'd12, 1'b1);
    halt = 1'b0; jump = 1'b0; branch_taken = 1'b0;

    // Restart from HALTED.
    start = 1'b1; start_addr = 10'h100;
    step();
    start = 1'b0;
    check_run("restart", 10'h100, 16'd0);

    // Reset mid-run beats jump and start.
    jump = 1'b1; jump_target = 10'h07A;
    step(); check_run("jmp7a", 10'h07A, 16'd1);
    reset = 1'b1; jump_target = 10'h155; start = 1'b1; start_addr = 10'h0AA;
    step();
    reset = 1'b0; jump = 1'b0; start = 1'b0;
    check_stopped("midreset", 10'h000, 16'd0, 1'b0);

    // Controls ignored in IDLE.
    jump = 1'b1; jump_target = 10'h123; halt = 1'b1; branch_taken = 1'b1;
    step(); check_stopped("idle_ign", 10'h000, 16'd0, 1'b0);
    jump = 1'b0; halt = 1'b0; branch_taken = 1'b0;

    // Start held during RUN has no effect.
    start = 1'b1; start_addr = 10'h040;
    step(); check_run("start40", 10'h040, 16'd0);
    start_addr = 10'h300;
    step(); check_run("start_ign", 10'h041, 16'd1);
    start = 1'b0;

    // Saturation of cycle_count.
    reset = 1'b1;
    step();
    reset = 1'b0; start = 1'b1; start_addr = 10'h000;
    step();
    start = 1'b0;
    check_run("sat0", 10'h000, 16'd0);
    repeat (65534) step();
    check("sat_pre", 32'(cycle_count), 32'd65534);
    step();
    check("sat_max", 32'(cycle_count), 32'hFFFF);
    repeat (4465) step();
    check("sat_hold", 32'(cycle_count), 32'hFFFF);
    check("sat_valid", 32'(instr_valid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
